pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Control FSM that drives program_counter in the pipelined Beta core. Every cycle it decides whether the PC advances, which pcsel mode the PC applies, and when the fetch stage is flushed or decode is stalled. It sits between decode/hazard logic and the PC. It resolves branch outcome locally, from the same zero-test the PC performs, so that it can generate the flush.

Parameters:
FLUSH_CYC, 1, cycles if_flush is held after a taken branch/jump (1..7)
RESOLVE_MAX, 8, max cycles spent waiting for a branch operand before timeout (1..255)

Ports:
clk  in  1  clock
rst  in  1  reset
clk_en_in  in  1  global pipeline enable; 0 freezes the FSM and its counters
id_valid  in  1  decode stage holds a valid instruction
id_op  in  2  00 none, 01 BEQ, 10 JMP, 11 BNE (same encoding as PC pcsel)
id_ra_hazard  in  1  branch/jump operand not yet forwarded
ra_zero  in  1  forwarded operand == 0
ld_use_hazard  in  1  load-use stall request
mem_busy  in  1  data memory not ready
pc_en  out  1  clk_en to program_counter
pcsel  out  2  mode to program_counter
if_flush  out  1  squash fetch/decode register
id_stall  out  1  hold decode register
br_taken  out  1  1-cycle pulse when a taken branch or jump issues
timeout_err  out  1  sticky; set on a RESOLVE timeout
state  out  2  current FSM state (debug)

Behaviour:
- Reset: rst is synchronous and active-high. State goes to RUN; counters clear; timeout_err clears. While rst=1, every output is 0 (pcsel=00).
- Outputs are combinational from state and inputs. State, counters and timeout_err are registered.
- clk_en_in=0: pc_en=0, if_flush=0, id_stall=1, br_taken=0. State and counters hold.
- Input priority, highest first: rst, clk_en_in, mem_busy, ld_use_hazard, branch handling.
- States use encoding RUN=0, STALL=1, RESOLVE=2, FLUSH=3.
- RUN:
  - If mem_busy or ld_use_hazard: pc_en=0, id_stall=1, next state STALL.
  - Else if id_valid and id_op!=00 and id_ra_hazard: pc_en=0, id_stall=1, resolve counter loads 1, next state RESOLVE.
  - Else if id_valid and id_op!=00: issue the branch.
  - Otherwise: pc_en=1, pcsel=00.
- Issue: pc_en=1, pcsel=id_op. taken = JMP, or BEQ with ra_zero=1, or BNE with ra_zero=0.
  - If taken: br_taken=1, if_flush=1, flush counter loads FLUSH_CYC-1. Next state is FLUSH if FLUSH_CYC>1, otherwise RUN.
  - If not taken: no flush, next state RUN.
- STALL: pc_en=0, id_stall=1. Stays while mem_busy or ld_use_hazard. When both are clear, pc_en=0 in that cycle and next state is RUN (one bubble).
- RESOLVE: pc_en=0, id_stall=1. Counter increments each cycle.
  - When id_ra_hazard=0 and no mem_busy: issue the branch as in RUN, in the same cycle.
  - If mem_busy: hold state, counter does not increment.
  - When counter reaches RESOLVE_MAX with the hazard still set: set timeout_err, issue pcsel=00 with pc_en=1 (branch dropped), next state RUN.
- FLUSH: if_flush=1, pc_en=1, pcsel=00. Branches in decode are ignored. Counter decrements; when it reaches 0, next state is RUN. If mem_busy: pc_en=0, counter holds, if_flush stays 1.
- Never: pc_en=1 together with id_stall=1; two br_taken pulses less than FLUSH_CYC+1 cycles apart.
- Reset mid-RESOLVE or mid-FLUSH: the pending branch is discarded, with no br_taken pulse.

Optional Feature:
- Macro PC_SEQ_PERF_EN.
- Defined: adds outputs taken_cnt[15:0] and stall_cnt[15:0].
  - taken_cnt counts br_taken pulses.
  - stall_cnt counts cycles with pc_en=0 while clk_en_in=1.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then id_valid=0 for 4 cycles -> pc_en=1, pcsel=00, if_flush=0 every cycle, state=0.
- BEQ with ra_zero=1, no hazards, FLUSH_CYC=2 -> issue cycle: pc_en=1, pcsel=01, br_taken=1, if_flush=1; next cycle: if_flush=1, pcsel=00; then state=0.
- BNE with ra_zero=1 -> pcsel=11, br_taken=0, if_flush=0, state stays RUN.
- JMP with id_ra_hazard=1 for 3 cycles -> 3 cycles of pc_en=0, id_stall=1, state=2; 4th cycle pcsel=10, br_taken=1.
- id_ra_hazard held with RESOLVE_MAX=8 -> on the 8th RESOLVE cycle timeout_err=1 and pcsel=00 with pc_en=1; timeout_err stays 1 until rst.
- mem_busy and ld_use_hazard together for 2 cycles, with a taken BEQ pending in decode -> pc_en=0 for 3 cycles (2 stall + 1 bubble), then the BEQ issues with pcsel=01; with PC_SEQ_PERF_EN, stall_cnt=3 and taken_cnt=1.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Decode/hazard <-> PC sequencer bundle. Perf counter signals exist only
// when PC_SEQ_PERF_EN is defined.
interface pc_sequencer_if;
  logic       clk_en_in;
  logic       id_valid;
  logic [1:0] id_op;
  logic       id_ra_hazard;
  logic       ra_zero;
  logic       ld_use_hazard;
  logic       mem_busy;
  logic       pc_en;
  logic [1:0] pcsel;
  logic       if_flush;
  logic       id_stall;
  logic       br_taken;
  logic       timeout_err;
  logic [1:0] state;
`ifdef PC_SEQ_PERF_EN
  logic [15:0] taken_cnt;
  logic [15:0] stall_cnt;
`endif

  modport master (
    output clk_en_in, id_valid, id_op, id_ra_hazard, ra_zero, ld_use_hazard, mem_busy,
    input  pc_en, pcsel, if_flush, id_stall, br_taken, timeout_err, state
`ifdef PC_SEQ_PERF_EN
    , input taken_cnt, stall_cnt
`endif
  );

  modport slave (
    input  clk_en_in, id_valid, id_op, id_ra_hazard, ra_zero, ld_use_hazard, mem_busy,
    output pc_en, pcsel, if_flush, id_stall, br_taken, timeout_err, state
`ifdef PC_SEQ_PERF_EN
    , output taken_cnt, stall_cnt
`endif
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC control FSM for the pipelined Beta core: advance/stall/flush decisions and
// local branch resolution. Define PC_SEQ_PERF_EN to add taken/stall counters.
module pc_sequencer #(
  parameter int FLUSH_CYC   = 1,
  parameter int RESOLVE_MAX = 8
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, RESOLVE = 2'd2, FLUSH = 2'd3} state_t;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_BEQ  = 2'b01;
  localparam logic [1:0] OP_JMP  = 2'b10;
  localparam logic [1:0] OP_BNE  = 2'b11;
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC - 1);
  localparam logic [7:0] RMAX       = 8'(RESOLVE_MAX);

  state_t     state_q, state_d;
  logic [7:0] rcnt_q, rcnt_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       timeout_q, timeout_d;
  logic       post_flush_q, post_flush_d;

  logic       pc_en, if_flush, id_stall, br_taken, timeout_now;
  logic [1:0] pcsel;
  logic       is_br, taken, hold, go;

  always_comb begin
    is_br = bus.id_valid && (bus.id_op != OP_NONE);
    hold  = bus.mem_busy || bus.ld_use_hazard;
    case (bus.id_op)
      OP_JMP:  taken = 1'b1;
      OP_BEQ:  taken = bus.ra_zero;
      OP_BNE:  taken = !bus.ra_zero;
      default: taken = 1'b0;
    endcase

    state_d      = state_q;
    rcnt_d       = rcnt_q;
    fcnt_d       = fcnt_q;
    timeout_d    = timeout_q;
    post_flush_d = post_flush_q;
    pc_en        = 1'b0;
    pcsel        = OP_NONE;
    if_flush     = 1'b0;
    id_stall     = 1'b0;
    br_taken     = 1'b0;
    timeout_now  = 1'b0;
    go           = 1'b0;

    if (!bus.clk_en_in) begin
      id_stall = 1'b1;
    end else begin
      post_flush_d = 1'b0;
      case (state_q)
        RUN: begin
          // The decode slot right after a flush holds a squashed instruction;
          // ignoring it keeps taken branches at least FLUSH_CYC+1 cycles apart.
          if (hold) begin
            id_stall = 1'b1;
            state_d  = STALL;
          end else if (is_br && !post_flush_q && bus.id_ra_hazard) begin
            id_stall = 1'b1;
            rcnt_d   = 8'd1;
            state_d  = RESOLVE;
          end else if (is_br && !post_flush_q) begin
            go = 1'b1;
          end else begin
            pc_en = 1'b1;
          end
        end
        STALL: begin
          id_stall = 1'b1;
          if (!hold) state_d = RUN;
        end
        RESOLVE: begin
          if (hold) begin
            id_stall = 1'b1;
          end else if (!bus.id_ra_hazard) begin
            go = 1'b1;
          end else if (rcnt_q >= RMAX) begin
            timeout_now = 1'b1;
            timeout_d   = 1'b1;
            pc_en       = 1'b1;
            state_d     = RUN;
          end else begin
            id_stall = 1'b1;
            rcnt_d   = rcnt_q + 8'd1;
          end
        end
        FLUSH: begin
          if_flush = 1'b1;
          if (!bus.mem_busy) begin
            pc_en  = 1'b1;
            fcnt_d = fcnt_q - 3'd1;
            if (fcnt_q <= 3'd1) begin
              state_d      = RUN;
              post_flush_d = 1'b1;
            end
          end
        end
        default: state_d = RUN;
      endcase

      if (go) begin
        pc_en   = 1'b1;
        pcsel   = bus.id_op;
        state_d = RUN;
        if (taken) begin
          br_taken = 1'b1;
          if_flush = 1'b1;
          fcnt_d   = FLUSH_LOAD;
          if (FLUSH_CYC > 1) state_d = FLUSH;
          else               post_flush_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      rcnt_q       <= '0;
      fcnt_q       <= '0;
      timeout_q    <= 1'b0;
      post_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      fcnt_q       <= fcnt_d;
      timeout_q    <= timeout_d;
      post_flush_q <= post_flush_d;
    end
  end

  assign bus.pc_en       = !rst && pc_en;
  assign bus.pcsel       = rst ? 2'b00 : pcsel;
  assign bus.if_flush    = !rst && if_flush;
  assign bus.id_stall    = !rst && id_stall;
  assign bus.br_taken    = !rst && br_taken;
  assign bus.timeout_err = !rst && (timeout_q || timeout_now);
  assign bus.state       = rst ? 2'b00 : state_q;

`ifdef PC_SEQ_PERF_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    taken_cnt_d = taken_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (br_taken && (taken_cnt_q != 16'hFFFF)) taken_cnt_d = taken_cnt_q + 16'd1;
    if (bus.clk_en_in && !pc_en && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.taken_cnt = rst ? 16'd0 : taken_cnt_q;
  assign bus.stall_cnt = rst ? 16'd0 : stall_cnt_q;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic, all outputs
// compared every cycle against a pending-branch / flush-budget model.
module tb_pc_sequencer;
  localparam int FLUSH_CYC   = 2;
  localparam int RESOLVE_MAX = 8;

  logic clk = 1'b0;
  logic rst;
  pc_sequencer_if bus();

  pc_sequencer #(.FLUSH_CYC(FLUSH_CYC), .RESOLVE_MAX(RESOLVE_MAX)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // model: flush cycles still owed, bubble in progress, branch waiting on operand
  int flush_left = 0, waited = 0, tcnt = 0, scnt = 0;
  bit bubble = 0, pend = 0, sticky = 0, guard = 0;
  int n_flush_left, n_waited, n_tcnt, n_scnt;
  bit n_bubble, n_pend, n_sticky, n_guard;
  int e_pc_en, e_pcsel, e_flush, e_stall, e_taken, e_tout, e_state, e_tc, e_sc;

  task automatic model_eval();
    bit busy, br, tk, go;
    busy = bus.mem_busy || bus.ld_use_hazard;
    br   = bus.id_valid && (bus.id_op != 2'd0);
    tk   = (bus.id_op == 2'd2) || (bus.id_op == 2'd1 && bus.ra_zero) ||
           (bus.id_op == 2'd3 && !bus.ra_zero);
    go = 0;
    e_pc_en = 0; e_pcsel = 0; e_flush = 0; e_stall = 0; e_taken = 0;
    e_tout  = sticky;
    e_state = (flush_left > 0) ? 3 : pend ? 2 : bubble ? 1 : 0;
    e_tc = tcnt; e_sc = scnt;
    n_flush_left = flush_left; n_waited = waited; n_tcnt = tcnt; n_scnt = scnt;
    n_bubble = bubble; n_pend = pend; n_sticky = sticky; n_guard = guard;
    if (rst) begin
      e_tout = 0; e_state = 0; e_tc = 0; e_sc = 0;
      n_flush_left = 0; n_waited = 0; n_tcnt = 0; n_scnt = 0;
      n_bubble = 0; n_pend = 0; n_sticky = 0; n_guard = 0;
    end else if (!bus.clk_en_in) begin
      e_stall = 1;
    end else begin
      n_guard = 0;
      if (flush_left > 0) begin
        e_flush = 1;
        if (!bus.mem_busy) begin
          e_pc_en = 1;
          n_flush_left = flush_left - 1;
          n_guard = (n_flush_left == 0);
        end
      end else if (bubble) begin
        e_stall = 1;
        n_bubble = busy;
      end else if (pend) begin
        if (busy) e_stall = 1;
        else if (!bus.id_ra_hazard) begin go = 1; n_pend = 0; end
        else if (waited >= RESOLVE_MAX) begin
          e_pc_en = 1; e_tout = 1; n_sticky = 1; n_pend = 0;
        end else begin
          e_stall = 1; n_waited = waited + 1;
        end
      end else if (busy) begin
        e_stall = 1; n_bubble = 1;
      end else if (br && !guard) begin
        if (bus.id_ra_hazard) begin e_stall = 1; n_pend = 1; n_waited = 1; end
        else go = 1;
      end else begin
        e_pc_en = 1;
      end
      if (go) begin
        e_pc_en = 1;
        e_pcsel = bus.id_op;
        if (tk) begin
          e_taken = 1; e_flush = 1;
          n_flush_left = FLUSH_CYC - 1;
          n_guard = (FLUSH_CYC == 1);
        end
      end
      if (!e_pc_en && scnt < 65535) n_scnt = scnt + 1;
      if (e_taken && tcnt < 65535) n_tcnt = tcnt + 1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    chk("pc_en", bus.pc_en, e_pc_en);
    chk("pcsel", bus.pcsel, e_pcsel);
    chk("if_flush", bus.if_flush, e_flush);
    chk("id_stall", bus.id_stall, e_stall);
    chk("br_taken", bus.br_taken, e_taken);
    chk("timeout_err", bus.timeout_err, e_tout);
    chk("state", bus.state, e_state);
    chk("en_with_stall", int'(bus.pc_en && bus.id_stall), 0);
`ifdef PC_SEQ_PERF_EN
    chk("taken_cnt", bus.taken_cnt, e_tc);
    chk("stall_cnt", bus.stall_cnt, e_sc);
`endif
  endtask

  task automatic adv();
    @(posedge clk);
    flush_left = n_flush_left; waited = n_waited; tcnt = n_tcnt; scnt = n_scnt;
    bubble = n_bubble; pend = n_pend; sticky = n_sticky; guard = n_guard;
    #1;
  endtask

  task automatic drv(bit v, bit [1:0] op, bit hz, bit rz, bit ld, bit mb, bit ce);
    bus.id_valid = v; bus.id_op = op; bus.id_ra_hazard = hz; bus.ra_zero = rz;
    bus.ld_use_hazard = ld; bus.mem_busy = mb; bus.clk_en_in = ce;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin drv(0, 2'd0, 0, 0, 0, 0, 1); step(); adv(); end
  endtask

  bit hz_r;

  initial begin
    rst = 1'b1;
    drv(0, 2'd0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      step(); chk("rst_pc_en", bus.pc_en, 0); chk("rst_stall", bus.id_stall, 0); adv();
    end
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      drv(0, 2'd0, 0, 0, 0, 0, 1); step();
      chk("idle_pc_en", bus.pc_en, 1); chk("idle_pcsel", bus.pcsel, 0);
      chk("idle_flush", bus.if_flush, 0); chk("idle_state", bus.state, 0);
      adv();
    end

    // taken BEQ
    drv(1, 2'd1, 0, 1, 0, 0, 1); step();
    chk("beq_pcsel", bus.pcsel, 1); chk("beq_taken", bus.br_taken, 1);
    chk("beq_flush", bus.if_flush, 1); chk("beq_pc_en", bus.pc_en, 1);
    adv();
    drv(0, 2'd0, 0, 0, 0, 0, 1); step();
    chk("beq_flush2", bus.if_flush, 1); chk("beq_pcsel2", bus.pcsel, 0); adv();
    step(); chk("beq_back_run", bus.state, 0); adv();

    // not-taken BNE
    drv(1, 2'd3, 0, 1, 0, 0, 1); step();
    chk("bne_pcsel", bus.pcsel, 3); chk("bne_taken", bus.br_taken, 0);
    chk("bne_flush", bus.if_flush, 0);
    adv();
    drv(0, 2'd0, 0, 0, 0, 0, 1); step(); chk("bne_state", bus.state, 0); adv();

    // JMP waiting on operand for 3 cycles
    for (int i = 0; i < 3; i++) begin
      drv(1, 2'd2, 1, 0, 0, 0, 1); step();
      chk("jmp_wait_pc_en", bus.pc_en, 0); chk("jmp_wait_stall", bus.id_stall, 1);
      if (i > 0) chk("jmp_wait_state", bus.state, 2);
      adv();
    end
    drv(1, 2'd2, 0, 0, 0, 0, 1); step();
    chk("jmp_pcsel", bus.pcsel, 2); chk("jmp_taken", bus.br_taken, 1); adv();
    idle(3);

    // operand never arrives -> timeout
    drv(1, 2'd1, 1, 0, 0, 0, 1); step(); adv();
    for (int i = 1; i <= RESOLVE_MAX; i++) begin
      step();
      chk("to_state", bus.state, 2);
      if (i == RESOLVE_MAX) begin
        chk("to_err", bus.timeout_err, 1); chk("to_pc_en", bus.pc_en, 1);
        chk("to_pcsel", bus.pcsel, 0);
      end else chk("to_err_early", bus.timeout_err, 0);
      adv();
    end
    for (int i = 0; i < 3; i++) begin
      drv(0, 2'd0, 0, 0, 0, 0, 1); step(); chk("to_sticky", bus.timeout_err, 1); adv();
    end
    rst = 1'b1; step(); chk("to_cleared", bus.timeout_err, 0); adv(); rst = 1'b0;

    // mem_busy + ld_use for 2 cycles with a taken BEQ waiting in decode
    for (int i = 0; i < 2; i++) begin
      drv(1, 2'd1, 0, 1, 1, 1, 1); step(); chk("stall_pc_en", bus.pc_en, 0); adv();
    end
    drv(1, 2'd1, 0, 1, 0, 0, 1); step();
    chk("bubble_pc_en", bus.pc_en, 0); chk("bubble_state", bus.state, 1); adv();
    step(); chk("stall_beq_pcsel", bus.pcsel, 1); chk("stall_beq_taken", bus.br_taken, 1); adv();
    drv(0, 2'd0, 0, 0, 0, 0, 1); step();
`ifdef PC_SEQ_PERF_EN
    chk("perf_stall_cnt", bus.stall_cnt, 3); chk("perf_taken_cnt", bus.taken_cnt, 1);
`endif
    adv();
    idle(2);

    // pipeline freeze with a branch in decode
    for (int i = 0; i < 2; i++) begin
      drv(1, 2'd2, 0, 0, 0, 0, 0); step(); chk("freeze_stall", bus.id_stall, 1); adv();
    end

    // reset while resolving and while flushing
    drv(1, 2'd2, 1, 0, 0, 0, 1); step(); adv(); step(); adv();
    rst = 1'b1; drv(1, 2'd2, 0, 0, 0, 0, 1); step(); chk("rst_res_taken", bus.br_taken, 0); adv();
    rst = 1'b0;
    drv(1, 2'd2, 0, 0, 0, 0, 1); step(); adv();
    rst = 1'b1; drv(0, 2'd0, 0, 0, 0, 0, 1); step(); chk("rst_fl_flush", bus.if_flush, 0); adv();
    rst = 1'b0;

    // random traffic
    hz_r = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) >= 8) hz_r = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 299) == 0);
      drv($urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)), hz_r, 1'($urandom_range(0, 1)),
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) != 0);
      step(); adv();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
